// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: holds the 3x3 board, alternates X/O, rejects illegal
// moves and reports win/draw status to the display stage.
module ttt_game_ctrl #(
   parameter bit FIRST_PLAYER = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  cursor,
   input  logic        selected,
   input  logic        new_game,
   output logic [17:0] board,
   output logic        player,
   output logic        move_ok,
   output logic        move_err,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic        draw,
   output logic [8:0]  win_mask
);

   localparam int unsigned N_CELLS = 9;
   localparam int unsigned N_LINES = 8;
   localparam int unsigned CNT_W   = 4;

   // Eight winning lines as cell masks: rows, columns, diagonals.
   localparam logic [71:0] LINES = {
      9'b001010100, 9'b100010001, 9'b100100100, 9'b010010010,
      9'b001001001, 9'b111000000, 9'b000111000, 9'b000000111
   };

   typedef enum logic [1:0] {S_PLAY, S_EVAL, S_DONE} state_t;

   state_t             r_state;
   logic               r_sel_q;
   logic [CNT_W-1:0]   r_count;
   logic [17:0]        r_board;
   logic               r_player;
   logic               r_move_ok;
   logic               r_move_err;
   logic               r_game_over;
   logic [1:0]         r_winner;
   logic               r_draw;
   logic [8:0]         r_win_mask;

   logic               w_sel_edge;
   logic               w_cursor_ok;
   logic [3:0]         w_safe_idx;
   logic [4:0]         w_bit_lo;
   logic [1:0]         w_cell;
   logic [1:0]         w_sym;
   logic [8:0]         w_hit;
   logic [8:0]         w_win_mask;

   assign w_sel_edge  = selected & ~r_sel_q;
   assign w_cursor_ok = (cursor <= 4'd8);
   assign w_safe_idx  = w_cursor_ok ? cursor : 4'd0;
   assign w_bit_lo    = {w_safe_idx, 1'b0};
   assign w_cell      = r_board[w_bit_lo +: 2];
   assign w_sym       = r_player ? 2'b10 : 2'b01;

   // Cells owned by the side that just moved, then the union of all completed lines.
   always_comb begin
      w_hit      = '0;
      w_win_mask = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         w_hit[i] = (r_board[2*i +: 2] == w_sym);
      end
      for (int l = 0; l < N_LINES; l++) begin
         if ((w_hit & LINES[9*l +: 9]) == LINES[9*l +: 9]) begin
            w_win_mask = w_win_mask | LINES[9*l +: 9];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_PLAY;
         r_sel_q     <= 1'b1;
         r_count     <= '0;
         r_board     <= '0;
         r_player    <= FIRST_PLAYER;
         r_move_ok   <= 1'b0;
         r_move_err  <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 2'b00;
         r_draw      <= 1'b0;
         r_win_mask  <= '0;
      end else begin
         r_sel_q    <= selected;
         r_move_ok  <= 1'b0;
         r_move_err <= 1'b0;
         if (new_game) begin
            r_state     <= S_PLAY;
            r_count     <= '0;
            r_board     <= '0;
            r_player    <= FIRST_PLAYER;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_draw      <= 1'b0;
            r_win_mask  <= '0;
         end else begin
            case (r_state)
               S_PLAY: begin
                  if (w_sel_edge) begin
                     if (!w_cursor_ok || (w_cell != 2'b00)) begin
                        r_move_err <= 1'b1;
                     end else begin
                        r_board[w_bit_lo +: 2] <= w_sym;
                        r_count                <= r_count + CNT_W'(1);
                        r_move_ok              <= 1'b1;
                        r_state                <= S_EVAL;
                     end
                  end
               end
               S_EVAL: begin
                  if (w_win_mask != 9'd0) begin
                     r_winner    <= w_sym;
                     r_win_mask  <= w_win_mask;
                     r_game_over <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (r_count == CNT_W'(9)) begin
                     r_draw      <= 1'b1;
                     r_game_over <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_player <= ~r_player;
                     r_state  <= S_PLAY;
                  end
               end
               S_DONE: ;
               default: r_state <= S_PLAY;
            endcase
         end
      end
   end

   assign board     = r_board;
   assign player    = r_player;
   assign move_ok   = r_move_ok;
   assign move_err  = r_move_err;
   assign game_over = r_game_over;
   assign winner    = r_winner;
   assign draw      = r_draw;
   assign win_mask  = r_win_mask;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: two instances (X first, O first) share stimulus and are
// compared every cycle against a cell-array game model, plus literal pins.
module tb_ttt_game_ctrl;

   logic        clk;
   logic        reset_n;
   logic [3:0]  cursor;
   logic        selected;
   logic        new_game;

   logic [17:0] board_w     [2];
   logic        player_w    [2];
   logic        move_ok_w   [2];
   logic        move_err_w  [2];
   logic        game_over_w [2];
   logic [1:0]  winner_w    [2];
   logic        draw_w      [2];
   logic [8:0]  win_mask_w  [2];

   int n_checks = 0;
   int n_errors = 0;

   ttt_game_ctrl #(.FIRST_PLAYER(1'b0)) u_dut_x (
      .clk(clk), .reset_n(reset_n), .cursor(cursor), .selected(selected), .new_game(new_game),
      .board(board_w[0]), .player(player_w[0]), .move_ok(move_ok_w[0]), .move_err(move_err_w[0]),
      .game_over(game_over_w[0]), .winner(winner_w[0]), .draw(draw_w[0]), .win_mask(win_mask_w[0])
   );

   ttt_game_ctrl #(.FIRST_PLAYER(1'b1)) u_dut_o (
      .clk(clk), .reset_n(reset_n), .cursor(cursor), .selected(selected), .new_game(new_game),
      .board(board_w[1]), .player(player_w[1]), .move_ok(move_ok_w[1]), .move_err(move_err_w[1]),
      .game_over(game_over_w[1]), .winner(winner_w[1]), .draw(draw_w[1]), .win_mask(win_mask_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural game model ----------------
   int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int   m_cell  [2][9];
   int   m_player[2];
   int   m_moves [2];
   int   m_phase [2];      // 0 waiting for a move, 1 judging last move, 2 game finished
   bit   m_ok    [2];
   bit   m_err   [2];
   bit   m_over  [2];
   bit   m_draw  [2];
   int   m_win   [2];
   int   m_mask  [2];
   bit   m_selq;

   function automatic void model_clear(int k);
      for (int i = 0; i < 9; i++) m_cell[k][i] = 0;
      m_player[k] = k;
      m_moves[k]  = 0;
      m_phase[k]  = 0;
      m_ok[k]     = 0;
      m_err[k]    = 0;
      m_over[k]   = 0;
      m_draw[k]   = 0;
      m_win[k]    = 0;
      m_mask[k]   = 0;
   endfunction

   function automatic void model_step(int k, bit sel_edge);
      int sym;
      int mask;
      m_ok[k]  = 0;
      m_err[k] = 0;
      if (new_game) begin
         model_clear(k);
         return;
      end
      sym = m_player[k] + 1;
      if (m_phase[k] == 0) begin
         if (sel_edge) begin
            if (cursor > 8 || m_cell[k][cursor] != 0) begin
               m_err[k] = 1;
            end else begin
               m_cell[k][cursor] = sym;
               m_moves[k]++;
               m_ok[k]    = 1;
               m_phase[k] = 1;
            end
         end
      end else if (m_phase[k] == 1) begin
         mask = 0;
         for (int l = 0; l < 8; l++) begin
            if (m_cell[k][lines[l][0]] == sym && m_cell[k][lines[l][1]] == sym &&
                m_cell[k][lines[l][2]] == sym)
               mask |= (1 << lines[l][0]) | (1 << lines[l][1]) | (1 << lines[l][2]);
         end
         if (mask != 0) begin
            m_win[k]   = sym;
            m_mask[k]  = mask;
            m_over[k]  = 1;
            m_phase[k] = 2;
         end else if (m_moves[k] == 9) begin
            m_draw[k]  = 1;
            m_over[k]  = 1;
            m_phase[k] = 2;
         end else begin
            m_player[k] = 1 - m_player[k];
            m_phase[k]  = 0;
         end
      end
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit sel_edge;
      if (!reset_n) begin
         m_selq = 1'b1;
         for (int k = 0; k < 2; k++) model_clear(k);
      end else begin
         sel_edge = selected && !m_selq;
         for (int k = 0; k < 2; k++) model_step(k, sel_edge);
         m_selq = selected;
      end
   end

   // ---------------- checking ----------------
   task automatic check(string name, int k, logic [17:0] got, logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [17:0] exp_board;
      for (int k = 0; k < 2; k++) begin
         exp_board = '0;
         for (int i = 0; i < 9; i++) exp_board[2*i +: 2] = 2'(m_cell[k][i]);
         check("board",     k, 18'(board_w[k]),     exp_board);
         check("player",    k, 18'(player_w[k]),    18'(m_player[k]));
         check("move_ok",   k, 18'(move_ok_w[k]),   18'(m_ok[k]));
         check("move_err",  k, 18'(move_err_w[k]),  18'(m_err[k]));
         check("game_over", k, 18'(game_over_w[k]), 18'(m_over[k]));
         check("winner",    k, 18'(winner_w[k]),    18'(m_win[k]));
         check("draw",      k, 18'(draw_w[k]),      18'(m_draw[k]));
         check("win_mask",  k, 18'(win_mask_w[k]),  18'(m_mask[k]));
      end
   end

   // ---------------- stimulus ----------------
   int seen_ok;
   int seen_err;

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // One select edge on cell c, then enough idle cycles for the judgement to land.
   task automatic select_cell(int c);
      cursor   = 4'(c);
      selected = 1'b1;
      step();
      seen_ok  = move_ok_w[0];
      seen_err = move_err_w[0];
      selected = 1'b0;
      step();
      step();
   endtask

   task automatic start_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      step();
   endtask

   task automatic play(int seq[], int n);
      for (int i = 0; i < n; i++) select_cell(seq[i]);
   endtask

   initial begin
      int cnt;
      int top_row[5]  = '{0, 3, 1, 4, 2};
      int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      int dbl_seq[9]  = '{1, 4, 2, 5, 3, 7, 6, 8, 0};

      reset_n  = 1'b0;
      cursor   = 4'd0;
      selected = 1'b1;
      new_game = 1'b0;
      step();
      step();

      // Select held through reset release must not become a move.
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         cnt += move_ok_w[0] + move_err_w[0];
      end
      check("held_through_reset_moves", 0, 18'(cnt), 18'd0);
      check("reset_board", 0, board_w[0], 18'd0);
      check("reset_player_o", 1, 18'(player_w[1]), 18'd1);
      selected = 1'b0;
      step();

      // Top-row win for X.
      play(top_row, 5);
      check("toprow_board",  0, board_w[0], 18'b000000001010010101);
      check("toprow_winner", 0, 18'(winner_w[0]), 18'd1);
      check("toprow_mask",   0, 18'(win_mask_w[0]), 18'b000000111);
      check("toprow_over",   0, 18'(game_over_w[0]), 18'd1);
      check("o_first_cell0", 1, 18'(board_w[1][1:0]), 18'b10);
      check("o_first_winner", 1, 18'(winner_w[1]), 18'b10);

      // Select while finished is ignored, new_game clears.
      select_cell(5);
      check("done_sel_ignored", 0, 18'(seen_err + seen_ok), 18'd0);
      start_new_game();
      check("ng_done_board",  0, board_w[0], 18'd0);
      check("ng_done_player", 1, 18'(player_w[1]), 18'd1);
      check("ng_done_over",   0, 18'(game_over_w[0]), 18'd0);

      // Illegal moves: occupied cell and out-of-range cursor.
      select_cell(4);
      select_cell(4);
      check("occupied_err", 0, 18'(seen_err), 18'd1);
      check("occupied_cell4", 0, 18'(board_w[0][9:8]), 18'b01);
      check("occupied_player", 0, 18'(player_w[0]), 18'd1);
      select_cell(9);
      check("cursor9_err", 0, 18'(seen_err), 18'd1);
      check("cursor9_ok", 0, 18'(seen_ok), 18'd0);

      // new_game coincident with a select edge wins.
      new_game = 1'b1;
      cursor   = 4'd0;
      selected = 1'b1;
      step();
      check("race_ok",     0, 18'(move_ok_w[0]), 18'd0);
      check("race_err",    0, 18'(move_err_w[0]), 18'd0);
      check("race_board",  0, board_w[0], 18'd0);
      check("race_player", 0, 18'(player_w[0]), 18'd0);
      new_game = 1'b0;
      selected = 1'b0;
      step();

      // Held select yields exactly one move.
      cursor   = 4'd6;
      selected = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         cnt += move_ok_w[0];
      end
      selected = 1'b0;
      check("held_select_moves", 0, 18'(cnt), 18'd1);
      step();

      // Draw.
      start_new_game();
      play(draw_seq, 9);
      check("draw_flag",   0, 18'(draw_w[0]), 18'd1);
      check("draw_winner", 0, 18'(winner_w[0]), 18'd0);
      check("draw_over",   0, 18'(game_over_w[0]), 18'd1);
      check("draw_mask",   0, 18'(win_mask_w[0]), 18'd0);

      // Double win on the final move: row 0 and column 0.
      start_new_game();
      play(dbl_seq, 9);
      check("dbl_mask",   0, 18'(win_mask_w[0]), 18'b001001111);
      check("dbl_winner", 0, 18'(winner_w[0]), 18'd1);
      check("dbl_draw",   0, 18'(draw_w[0]), 18'd0);

      // Randomized play with occasional new_game and reset.
      start_new_game();
      for (int it = 0; it < 3000; it++) begin
         int r;
         r = int'($urandom_range(0, 99));
         new_game = 1'b0;
         reset_n  = 1'b1;
         if (r < 1) begin
            reset_n  = 1'b0;
            selected = 1'($urandom_range(0, 1));
         end else if (r < 5) begin
            new_game = 1'b1;
            selected = 1'($urandom_range(0, 1));
         end else begin
            cursor   = 4'($urandom_range(0, 10));
            selected = 1'($urandom_range(0, 1));
         end
         step();
      end
      reset_n  = 1'b1;
      new_game = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
